spi_word_master: RTL and testbench
==================================

# spi_word_master

Single-word SPI master (mode 0, MSB first) that consumes the 16-bit `tx_data`/`dv` pulse stream and `reset` produced by the SPI transmit controller. It serialises each word onto `sclk`/`mosi` under an active-low chip select and captures `miso` into `rx_data`. A one-entry holding buffer absorbs a word that arrives while a frame is in flight, because the upstream has no backpressure.

## Interface
- `DATA_W`, 16: word width in bits.
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period. Legal values are 2 or more; elaboration fails below 2.

- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high. Driven by the upstream `reset`.
- `tx_data` in DATA_W: word to transmit. Sampled only when `dv`=1.
- `dv` in 1: single-cycle data-valid strobe. No ready is returned.
- `miso` in 1: serial input from the slave.
- `sclk` out 1: SPI clock; idles low.
- `mosi` out 1: serial output.
- `cs_n` out 1: chip select, active low.
- `busy` out 1: high from the cycle after acceptance until the end of GAP.
- `done` out 1: one-cycle pulse in the cycle `cs_n` rises.
- `rx_data` out DATA_W: last captured word.
- `rx_valid` out 1: one-cycle pulse, coincident with `done`.
- `overrun` out 1: sticky flag; a word was dropped.

## Operation
- FSM states and transitions:
  - IDLE to SETUP on `dv`.
  - SETUP to SHIFT after CLK_DIV cycles.
  - SHIFT to HOLD after 2·DATA_W half-periods.
  - HOLD to GAP after CLK_DIV cycles.
  - GAP to IDLE after CLK_DIV cycles. If the buffer is full, GAP goes to SETUP instead.
- Acceptance in IDLE: `tx_data` loads the shift register; `cs_n`=0, `mosi`=bit DATA_W-1 and `busy`=1 from the next cycle.
- Shifting:
  - Divider counter runs 0..CLK_DIV-1; SCLK toggles at terminal count during SHIFT only.
  - Rising edge: sample `miso` into the rx shift register (LSB in, shift left).
  - Falling edge: shift tx left, present the next bit on `mosi`. After the last falling edge `sclk`=0 and `mosi` holds the last bit.
- Buffering:
  - `dv` while `busy`=1 and buffer empty: the word is stored.
  - `dv` while the buffer is full: the word is dropped and `overrun` is set.
- Boundary case, last cycle of GAP with buffer full and `dv`=1: the buffered word starts a frame and the new word takes the buffer slot (pop and push in the same cycle). No overrun.
- Boundary case, `dv` in the same cycle `done` pulses: the word goes to the buffer.
- Reset behaviour, including mid-frame:
  - Next cycle: `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_valid`=0, `rx_data`=0, `overrun`=0.
  - Buffer emptied, FSM in IDLE, divider cleared.
  - `dv` coincident with `reset` is ignored.

## Timing
- `dv` at cycle 0 gives `cs_n` low at cycle 1.
- First SCLK rise at cycle 1+CLK_DIV.
- Bit period is 2·CLK_DIV cycles.
- `cs_n` low for (2·DATA_W+2)·CLK_DIV cycles: 136 with defaults.
- `done`/`rx_valid` pulse in the first GAP cycle; `rx_data` is updated in the same cycle.
- Back-to-back minimum frame spacing: `cs_n` high for CLK_DIV cycles.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `SPI_MISO_CAPTURE_EN` defined: rx shift register present; `rx_data`/`rx_valid` behave as above.
- `SPI_MISO_CAPTURE_EN` undefined: rx logic removed; `rx_data` tied 0, `rx_valid` tied 0, `miso` unused. TX timing is identical.

## Structure
- Shared package `spi_pkg` holds:
  - FSM state enum `spi_state_t` (IDLE, SETUP, SHIFT, HOLD, GAP).
  - Default constants `SPI_DATA_W`=16 and `SPI_CLK_DIV`=4.
- One sub-module, `spi_clk_div`: divider counter, SCLK toggle, and rise/fall strobes, enabled only in SHIFT.

## Test plan
- Reset, then `dv` with `tx_data`=0x0BB8 (3000): `mosi` bits at the 16 rising edges are 0,0,0,0,1,0,1,1,1,0,1,1,1,0,0,0. `cs_n` is low for 136 cycles and `done` pulses once.
- Loopback `miso`=`mosi` with `SPI_MISO_CAPTURE_EN` defined and word 0xA5C3: `rx_data`=0xA5C3 with `rx_valid` in the `done` cycle. With the macro undefined: `rx_data`=0 and `rx_valid` never pulses.
- Three `dv` pulses 10 cycles apart (0x1111, 0x2222, 0x3333): frames 1 and 2 are sent, 0x3333 is dropped and `overrun`=1. Inter-frame `cs_n` high is exactly 4 cycles.
- Buffer full, with `dv`=0x4444 in the last GAP cycle: 0x2222 starts a frame, 0x4444 is sent next, and `overrun` stays 0.
- `reset` asserted at SCLK rise 7: next cycle `cs_n`=1, `sclk`=0, `busy`=0. A subsequent `dv`=0x00FF is sent cleanly.
- CLK_DIV=2 with word 0xFFFF: SCLK period is 4 cycles and `cs_n` is low for 68 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the single-word SPI master slice.
//   spi_state_t : frame sequencing states (IDLE, SETUP, SHIFT, HOLD, GAP)
//   SPI_DATA_W  : default word width
//   SPI_CLK_DIV : default clk cycles per SCLK half-period
//   cnt_width() : counter width able to hold 0..n-1 (never below 1 bit)
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_DATA_W  = 16;
    localparam int SPI_CLK_DIV = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div
// Phase counter and SCLK generator for spi_word_master.
// The counter runs 0..CLK_DIV-1 while count_en is high; every terminal count
// marks the end of one SCLK half-period. SCLK toggles on a terminal count
// only while toggle_en is high, so the parent decides which half-periods
// actually produce an edge.
//
// Ports:
//   clk       in  : system clock
//   reset     in  : synchronous, active-high
//   count_en  in  : advance the phase counter
//   toggle_en in  : allow SCLK to toggle at terminal count
//   terminal  out : counter is at CLK_DIV-1 this cycle (and counting)
//   sclk      out : registered SPI clock, idles low
//   rise      out : SCLK goes high at the coming clock edge
//   fall      out : SCLK goes low at the coming clock edge
// ---------------------------------------------------------------------------
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    input  logic toggle_en,
    output logic terminal,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // Strobes are decoded one cycle ahead so the parent can update its own
    // registers in the same edge that moves SCLK.
    assign terminal = count_en && (count == LAST_COUNT);
    assign rise     = terminal && toggle_en && !sclk;
    assign fall     = terminal && toggle_en && sclk;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            sclk  <= 1'b0;
        end else if (count_en) begin
            count <= terminal ? '0 : count + 1'b1;
            if (terminal && toggle_en) begin
                sclk <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/spi_word_master.sv
// ---------------------------------------------------------------------------
// spi_word_master
// Single-word SPI master, mode 0, MSB first. Each dv strobe starts (or
// queues) one DATA_W-bit frame under an active-low chip select. A one-entry
// holding buffer absorbs a word arriving during a frame; a further word while
// the buffer is full is dropped and the sticky overrun flag is raised.
//
// Frame shape (CLK_DIV cycles per phase unit):
//   SETUP 1 unit, SHIFT 2*DATA_W units, HOLD 1 unit -> cs_n low,
//   GAP 1 unit -> cs_n high, done/rx_valid pulse in its first cycle.
//
// Optional feature macro: SPI_MISO_CAPTURE_EN
//   defined   : miso is shifted in on SCLK rising edges, rx_data/rx_valid live
//   undefined : receive path removed, rx_data = 0, rx_valid = 0, miso unused
//
// Ports:
//   clk      in  : system clock
//   reset    in  : synchronous, active-high
//   tx_data  in  : word to transmit, sampled when dv = 1
//   dv       in  : single-cycle data-valid strobe (no backpressure)
//   miso     in  : serial data from slave
//   sclk     out : SPI clock, idles low
//   mosi     out : serial data to slave
//   cs_n     out : chip select, active low
//   busy     out : a frame is in progress (SETUP through GAP)
//   done     out : one-cycle pulse as cs_n rises
//   rx_data  out : last captured word
//   rx_valid out : one-cycle pulse with done
//   overrun  out : sticky, a word was dropped
// ---------------------------------------------------------------------------
module spi_word_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              dv,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              overrun
);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("spi_word_master: CLK_DIV must be 2 or more");
    end

    localparam int HW = cnt_width(2 * DATA_W);
    localparam logic [HW-1:0] LAST_HALF = HW'(2 * DATA_W - 1);
    localparam logic [HW-1:0] LAST_FALL = HW'(2 * DATA_W - 2);

    spi_state_t        state;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] buf_data;
    logic              buf_full;
    logic [HW-1:0]     half_cnt;

    logic div_count_en;
    logic div_toggle_en;
    logic div_terminal;
    logic sclk_rise;
    logic sclk_fall;
    logic pop_at_gap;

    // The phase counter runs through every active state so SETUP, HOLD and
    // GAP all last exactly CLK_DIV cycles. SETUP's terminal count produces
    // the first rising edge, which is why SCLK is already high in the first
    // SHIFT cycle. The final SHIFT half-period only closes the frame.
    assign div_count_en  = (state != IDLE);
    assign div_toggle_en = (state == SETUP) ||
                           ((state == SHIFT) && (half_cnt != LAST_HALF));

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .reset     (reset),
        .count_en  (div_count_en),
        .toggle_en (div_toggle_en),
        .terminal  (div_terminal),
        .sclk      (sclk),
        .rise      (sclk_rise),
        .fall      (sclk_fall)
    );

    // mosi is the MSB of a register, so it is a flop output with no
    // combinational path from any input.
    assign mosi       = tx_shift[DATA_W-1];
    assign pop_at_gap = (state == GAP) && div_terminal && buf_full;

    // Frame sequencer. A frame starts from IDLE either on a fresh dv or on a
    // word left in the buffer (stored during the last GAP cycle). At the end
    // of GAP a full buffer chains straight into the next SETUP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_shift <= '0;
            half_cnt <= '0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dv || buf_full) begin
                        tx_shift <= buf_full ? buf_data : tx_data;
                        half_cnt <= '0;
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_terminal) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The last falling edge leaves the final bit on mosi.
                    if (sclk_fall && (half_cnt != LAST_FALL)) begin
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    end
                    if (div_terminal) begin
                        if (half_cnt == LAST_HALF) begin
                            half_cnt <= '0;
                            state    <= HOLD;
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (div_terminal) begin
                        cs_n  <= 1'b1;
                        done  <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (div_terminal) begin
                        if (buf_full) begin
                            tx_shift <= buf_data;
                            half_cnt <= '0;
                            cs_n     <= 1'b0;
                            state    <= SETUP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Holding buffer. In IDLE a fresh dv goes straight to the shifter unless
    // a buffered word is pending, in which case the two swap places. During a
    // frame a word fills an empty slot, replaces a slot being popped this
    // cycle, or is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_data <= '0;
            buf_full <= 1'b0;
            overrun  <= 1'b0;
        end else if (state == IDLE) begin
            if (buf_full) begin
                if (dv) begin
                    buf_data <= tx_data;
                end else begin
                    buf_full <= 1'b0;
                end
            end
        end else begin
            if (dv) begin
                if (pop_at_gap || !buf_full) begin
                    buf_data <= tx_data;
                    buf_full <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pop_at_gap) begin
                buf_full <= 1'b0;
            end
        end
    end

`ifdef SPI_MISO_CAPTURE_EN
    logic [DATA_W-1:0] rx_shift;

    // miso is sampled as SCLK rises; the full word is published as the HOLD
    // phase ends, landing with done in the first GAP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (sclk_rise) begin
                rx_shift <= {rx_shift[DATA_W-2:0], miso};
            end
            if ((state == HOLD) && div_terminal) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_rx_inputs;

    assign unused_rx_inputs = miso ^ sclk_rise;
    assign rx_data          = '0;
    assign rx_valid         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_master.sv
// ---------------------------------------------------------------------------
// tb_spi_word_master
// Directed self-checking bench for spi_word_master. Instance u_dut uses the
// default CLK_DIV=4, instance u_dut_b uses CLK_DIV=2. miso is looped back
// from mosi on both. Monitors collect frame shape and transmitted words at
// SCLK rising edges; the main sequence checks them against hand values.
// ---------------------------------------------------------------------------
module tb_spi_word_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tx_data, tx_b;
    logic        dv, dv_b;
    logic        sclk, mosi, cs_n, busy, done, rx_valid, overrun;
    logic [15:0] rx_data;
    logic        sclk_b, mosi_b, cs_n_b, busy_b, done_b, rx_valid_b, overrun_b;
    logic [15:0] rx_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_word_master u_dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .dv       (dv),
        .miso     (mosi),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .overrun  (overrun)
    );

    spi_word_master #(.DATA_W(16), .CLK_DIV(2)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_b),
        .dv       (dv_b),
        .miso     (mosi_b),
        .sclk     (sclk_b),
        .mosi     (mosi_b),
        .cs_n     (cs_n_b),
        .busy     (busy_b),
        .done     (done_b),
        .rx_data  (rx_data_b),
        .rx_valid (rx_valid_b),
        .overrun  (overrun_b)
    );

    // Frame monitor for u_dut, sampled 2 time units after each rising edge.
    int          cyc, fall_cyc, last_rise_cyc;
    int          frame_rises, low_cnt, high_cnt, low_len, gap_len;
    int          first_rise_delay, rise_period;
    int          frames, done_cnt, done_bad, rxv_cnt;
    logic [15:0] mosi_word = '0;
    logic [15:0] done_rx = '0;
    logic        done_rxv = 1'b0;
    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;
    logic [15:0] word_q[$];

    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (!cs_n && prev_cs) begin
            fall_cyc    = cyc;
            frame_rises = 0;
            mosi_word   = '0;
            gap_len     = high_cnt;
            low_cnt     = 0;
        end
        if (cs_n && !prev_cs) begin
            low_len  = low_cnt;
            high_cnt = 0;
            frames++;
            word_q.push_back(mosi_word);
        end
        if (!cs_n) low_cnt++;
        else       high_cnt++;
        if (sclk && !prev_sclk) begin
            mosi_word = {mosi_word[14:0], mosi};
            frame_rises++;
            if (frame_rises == 1)      first_rise_delay = cyc - fall_cyc;
            else if (frame_rises == 2) rise_period = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_rx  = rx_data;
            done_rxv = rx_valid;
            if (!(cs_n && !prev_cs)) done_bad++;
        end
        if (rx_valid) rxv_cnt++;
        prev_sclk = sclk;
        prev_cs   = cs_n;
    end

    // Reduced monitor for the CLK_DIV=2 instance.
    int          cyc_b, fall_cyc_b, last_rise_b, rises_b;
    int          low_cnt_b, low_len_b, first_b, period_b, frames_b;
    logic [15:0] word_b = '0;
    logic        prev_sclk_b = 1'b0;
    logic        prev_cs_b = 1'b1;

    always begin
        @(posedge clk);
        #2;
        cyc_b++;
        if (!cs_n_b && prev_cs_b) begin
            fall_cyc_b = cyc_b;
            rises_b    = 0;
            word_b     = '0;
            low_cnt_b  = 0;
        end
        if (cs_n_b && !prev_cs_b) begin
            low_len_b = low_cnt_b;
            frames_b++;
        end
        if (!cs_n_b) low_cnt_b++;
        if (sclk_b && !prev_sclk_b) begin
            word_b = {word_b[14:0], mosi_b};
            rises_b++;
            if (rises_b == 1)      first_b = cyc_b - fall_cyc_b;
            else if (rises_b == 2) period_b = cyc_b - last_rise_b;
            last_rise_b = cyc_b;
        end
        prev_sclk_b = sclk_b;
        prev_cs_b   = cs_n_b;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One-cycle dv strobe; returns at the falling edge after it was sampled.
    task automatic applyStimulus(input bit to_b, input logic [15:0] word);
        if (to_b) begin
            tx_b = word;
            dv_b = 1'b1;
        end else begin
            tx_data = word;
            dv      = 1'b1;
        end
        @(negedge clk);
        dv   = 1'b0;
        dv_b = 1'b0;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitFrames(input int target, input string tag);
        int n = 0;
        while (frames < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(frames >= target), 32'd1);
    endtask

    initial begin
        int base_f;
        int base_done;
        int n;

        reset   = 1'b1;
        dv      = 1'b0;
        dv_b    = 1'b0;
        tx_data = '0;
        tx_b    = '0;
        repeat (3) @(negedge clk);

        // dv coincident with reset must be ignored
        tx_data = 16'hFFFF;
        dv      = 1'b1;
        @(negedge clk);
        dv    = 1'b0;
        reset = 1'b0;
        checkOutput("rst_cs_n",     32'(cs_n),     32'd1);
        checkOutput("rst_sclk",     32'(sclk),     32'd0);
        checkOutput("rst_mosi",     32'(mosi),     32'd0);
        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_done",     32'(done),     32'd0);
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("rst_rx_data",  32'(rx_data),  32'd0);
        checkOutput("rst_overrun",  32'(overrun),  32'd0);
        @(negedge clk);
        checkOutput("dv_in_reset_busy", 32'(busy), 32'd0);
        checkOutput("dv_in_reset_cs_n", 32'(cs_n), 32'd1);

        // Frame of 0x0BB8: timing and bit order
        $display("[TB] frame 0x0BB8");
        word_q.delete();
        base_f    = frames;
        base_done = done_cnt;
        applyStimulus(0, 16'h0BB8);
        checkOutput("t1_cs_n_low",   32'(cs_n), 32'd0);
        checkOutput("t1_busy",       32'(busy), 32'd1);
        checkOutput("t1_first_mosi", 32'(mosi), 32'd0);
        checkOutput("t1_sclk_idle",  32'(sclk), 32'd0);
        waitFrames(base_f + 1, "t1_timeout");
        checkOutput("t1_word",        32'(word_q[0]),  32'h0BB8);
        checkOutput("t1_cs_low_len",  32'(low_len),    32'd136);
        checkOutput("t1_first_rise",  32'(first_rise_delay), 32'd4);
        checkOutput("t1_bit_period",  32'(rise_period), 32'd8);
        checkOutput("t1_rise_count",  32'(frame_rises), 32'd16);
        checkOutput("t1_done_pulses", 32'(done_cnt - base_done), 32'd1);
        repeat (6) @(negedge clk);
        checkOutput("t1_busy_after", 32'(busy), 32'd0);

        // Loopback of 0xA5C3
        $display("[TB] loopback 0xA5C3");
        word_q.delete();
        base_f = frames;
        applyStimulus(0, 16'hA5C3);
        checkOutput("t2_first_mosi", 32'(mosi), 32'd1);
        waitFrames(base_f + 1, "t2_timeout");
        checkOutput("t2_word", 32'(word_q[0]), 32'hA5C3);
`ifdef SPI_MISO_CAPTURE_EN
        checkOutput("t2_rx_at_done",    32'(done_rx),  32'hA5C3);
        checkOutput("t2_rxv_with_done", 32'(done_rxv), 32'd1);
        checkOutput("t2_rx_data",       32'(rx_data),  32'hA5C3);
        checkOutput("t2_rxv_count",     32'(rxv_cnt),  32'(done_cnt));
`else
        checkOutput("t2_rx_data_zero",  32'(rx_data),  32'd0);
        checkOutput("t2_rx_at_done",    32'(done_rx),  32'd0);
        checkOutput("t2_rxv_never",     32'(rxv_cnt),  32'd0);
`endif
        repeat (6) @(negedge clk);

        // Three words 10 cycles apart: third is dropped
        $display("[TB] overrun sequence");
        applyReset();
        word_q.delete();
        base_f = frames;
        applyStimulus(0, 16'h1111);
        repeat (9) @(negedge clk);
        applyStimulus(0, 16'h2222);
        checkOutput("t3_no_overrun_yet", 32'(overrun), 32'd0);
        repeat (9) @(negedge clk);
        applyStimulus(0, 16'h3333);
        checkOutput("t3_overrun_set", 32'(overrun), 32'd1);
        waitFrames(base_f + 2, "t3_timeout");
        checkOutput("t3_word0",   32'(word_q[0]), 32'h1111);
        checkOutput("t3_word1",   32'(word_q[1]), 32'h2222);
        checkOutput("t3_gap_len", 32'(gap_len),   32'd4);
        repeat (200) @(negedge clk);
        checkOutput("t3_no_third_frame", 32'(frames),  32'(base_f + 2));
        checkOutput("t3_overrun_sticky", 32'(overrun), 32'd1);
        checkOutput("t3_idle_busy",      32'(busy),    32'd0);

        // Push and pop in the last GAP cycle (cycle 140)
        $display("[TB] pop and push in last gap cycle");
        applyReset();
        checkOutput("t4_overrun_cleared", 32'(overrun), 32'd0);
        word_q.delete();
        base_f = frames;
        applyStimulus(0, 16'h1111);
        repeat (9) @(negedge clk);
        applyStimulus(0, 16'h2222);
        repeat (129) @(negedge clk);
        applyStimulus(0, 16'h4444);
        checkOutput("t4_frame2_started", 32'(cs_n), 32'd0);
        waitFrames(base_f + 3, "t4_timeout");
        checkOutput("t4_word0",   32'(word_q[0]), 32'h1111);
        checkOutput("t4_word1",   32'(word_q[1]), 32'h2222);
        checkOutput("t4_word2",   32'(word_q[2]), 32'h4444);
        checkOutput("t4_gap_len", 32'(gap_len),   32'd4);
        checkOutput("t4_overrun", 32'(overrun),   32'd0);
        repeat (6) @(negedge clk);

        // Reset at the 7th SCLK rise, then a clean frame
        $display("[TB] reset mid-frame");
        applyStimulus(0, 16'hC0DE);
        n = 0;
        while (frame_rises < 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_rise7_reached", 32'(frame_rises), 32'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t5_cs_n", 32'(cs_n), 32'd1);
        checkOutput("t5_sclk", 32'(sclk), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_mosi", 32'(mosi), 32'd0);
        checkOutput("t5_done", 32'(done), 32'd0);
        word_q.delete();
        base_f = frames;
        @(negedge clk);
        applyStimulus(0, 16'h00FF);
        waitFrames(base_f + 1, "t5_timeout");
        checkOutput("t5_word",       32'(word_q[0]),       32'h00FF);
        checkOutput("t5_cs_low_len", 32'(low_len),         32'd136);
        checkOutput("t5_first_rise", 32'(first_rise_delay), 32'd4);
        checkOutput("t5_overrun",    32'(overrun),         32'd0);
        checkOutput("done_alignment", 32'(done_bad),       32'd0);

        // CLK_DIV=2 instance with 0xFFFF
        $display("[TB] CLK_DIV=2 frame");
        applyStimulus(1, 16'hFFFF);
        n = 0;
        while (frames_b < 1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_frame_seen",  32'(frames_b),  32'd1);
        checkOutput("t6_word",        32'(word_b),    32'hFFFF);
        checkOutput("t6_cs_low_len",  32'(low_len_b), 32'd68);
        checkOutput("t6_sclk_period", 32'(period_b),  32'd4);
        checkOutput("t6_first_rise",  32'(first_b),   32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
